screen_writer: RTL and testbench

- Write-side companion to the VGA scanout reader; owns the write half of the shared 8K x 16 screen VRAM port (Hack screen, 512x256, 1 bpp, 32 words per line).
- Buffers CPU screen writes in a small FIFO and commits them only on cycles when scanout is not reading.
- Provides a hardware clear engine that fills all 8192 words with a fixed value.
- Scanout always has priority; this block never drives a write in a cycle where vga_rden is high.

---
 rtl/screen_writer_if.sv | 30 +++
 rtl/screen_writer.sv | 142 ++++++++++++++
 tb/tb_screen_writer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_writer_if.sv
// Bus bundle between a screen writer and its environment: CPU write queue,
// clear engine control, scanout read enable and the VRAM write port.
interface screen_writer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_busy;
    logic              clr_start;
    logic [DATA_W-1:0] clr_value;
    logic              clr_busy;
    logic              clr_done;
    logic              vga_rden;
    logic              vram_wren;
    logic [ADDR_W-1:0] vram_waddr;
    logic [DATA_W-1:0] vram_wdata;
    logic              pending;

    modport master (
        output cpu_wr_en, cpu_wr_addr, cpu_wr_data, clr_start, clr_value, vga_rden,
        input  cpu_busy, clr_busy, clr_done, vram_wren, vram_waddr, vram_wdata, pending
    );

    modport slave (
        input  cpu_wr_en, cpu_wr_addr, cpu_wr_data, clr_start, clr_value, vga_rden,
        output cpu_busy, clr_busy, clr_done, vram_wren, vram_waddr, vram_wdata, pending
    );
endinterface

// File: rtl/screen_writer.sv
// Write side of the shared screen VRAM port: queues CPU writes, runs a
// full-screen clear engine, and only writes on cycles scanout is not reading.
module screen_writer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    screen_writer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [DATA_W-1:0] clr_val_r;
    logic              clr_done_r;

    logic              full_s;
    logic              pending_s;
    logic              push_s;
    logic              pop_s;
    logic              wren_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    entry_t            head_s;

    // Write-port selection; scanout priority is enforced by gating on vga_rden.
    always_comb begin
        full_s    = (count_r == FULL_CNT);
        pending_s = (count_r != {CNT_W{1'b0}});
        push_s    = bus.cpu_wr_en && !full_s;
        head_s    = mem_r[rd_ptr_r];
        wren_s    = 1'b0;
        waddr_s   = head_s.addr;
        wdata_s   = head_s.data;
        case (state_r)
            ST_IDLE: begin
                wren_s  = !bus.vga_rden && pending_s;
                waddr_s = head_s.addr;
                wdata_s = head_s.data;
            end
            ST_CLEAR: begin
                wren_s  = !bus.vga_rden;
                waddr_s = clr_cnt_r;
                wdata_s = clr_val_r;
            end
            default: begin
                wren_s  = 1'b0;
                waddr_s = head_s.addr;
                wdata_s = head_s.data;
            end
        endcase
        if (state_r == ST_IDLE) begin
            pop_s = wren_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign bus.cpu_busy   = full_s;
    assign bus.pending    = pending_s;
    assign bus.clr_busy   = (state_r == ST_CLEAR);
    assign bus.clr_done   = clr_done_r;
    assign bus.vram_wren  = wren_s;
    assign bus.vram_waddr = waddr_s;
    assign bus.vram_wdata = wdata_s;

    // CPU write FIFO; storage is reset so the idle write port reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {($bits(entry_t)){1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {bus.cpu_wr_addr, bus.cpu_wr_data};
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Clear engine state machine; a clear only starts once the FIFO is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            clr_cnt_r  <= {ADDR_W{1'b0}};
            clr_val_r  <= {DATA_W{1'b0}};
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.clr_start && !pending_s) begin
                        state_r   <= ST_CLEAR;
                        clr_val_r <= bus.clr_value;
                        clr_cnt_r <= {ADDR_W{1'b0}};
                    end
                end
                ST_CLEAR: begin
                    if (wren_s) begin
                        clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (&clr_cnt_r) begin
                            state_r    <= ST_IDLE;
                            clr_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_screen_writer.sv
// Self-checking bench for screen_writer: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_screen_writer;
    localparam int DEPTH = 4;
    localparam int WORDS = 8192;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    screen_writer_if #(.ADDR_W(13), .DATA_W(16)) bus ();

    screen_writer #(.DEPTH(DEPTH), .ADDR_W(13), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_clear;
    int          m_idx;
    logic [15:0] m_fill;
    bit          m_done;

    logic        o_wren, o_pending, o_busy, o_clr_busy, o_clr_done;
    logic [12:0] o_addr;
    logic [15:0] o_data;
    int          wr_cnt;
    int          cov[WORDS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_clear = 1'b0;
        m_idx   = 0;
        m_done  = 1'b0;
    endtask

    task automatic reset_check();
        chk("rst_wren",     {31'd0, bus.vram_wren}, 32'd0);
        chk("rst_waddr",    {19'd0, bus.vram_waddr}, 32'd0);
        chk("rst_wdata",    {16'd0, bus.vram_wdata}, 32'd0);
        chk("rst_busy",     {31'd0, bus.cpu_busy}, 32'd0);
        chk("rst_clr_busy", {31'd0, bus.clr_busy}, 32'd0);
        chk("rst_clr_done", {31'd0, bus.clr_done}, 32'd0);
        chk("rst_pending",  {31'd0, bus.pending}, 32'd0);
    endtask

    // One clock: observe at negedge, compare with the model, advance the model.
    task automatic cycle();
        logic        e_wren;
        logic [12:0] e_a;
        logic [15:0] e_d;
        int          sz;
        bit          push;
        @(negedge clk);
        o_wren     = bus.vram_wren;
        o_addr     = bus.vram_waddr;
        o_data     = bus.vram_wdata;
        o_pending  = bus.pending;
        o_busy     = bus.cpu_busy;
        o_clr_busy = bus.clr_busy;
        o_clr_done = bus.clr_done;
        if (o_wren === 1'b1) wr_cnt++;
        if (o_wren === 1'b1 && o_clr_busy === 1'b1 && o_data === 16'hFFFF) cov[o_addr]++;

        sz     = q.size();
        e_wren = m_clear ? !bus.vga_rden : (!bus.vga_rden && sz > 0);
        chk("wren",       {31'd0, o_wren}, {31'd0, e_wren});
        chk("pending",    {31'd0, o_pending}, {31'd0, sz != 0});
        chk("cpu_busy",   {31'd0, o_busy}, {31'd0, sz == DEPTH});
        chk("clr_busy",   {31'd0, o_clr_busy}, {31'd0, m_clear});
        chk("clr_done",   {31'd0, o_clr_done}, {31'd0, m_done});
        chk("no_collide", {31'd0, o_wren & bus.vga_rden}, 32'd0);
        if (e_wren) begin
            e_a = m_clear ? 13'(m_idx) : q[0].a;
            e_d = m_clear ? m_fill : q[0].d;
            chk("waddr", {19'd0, o_addr}, {19'd0, e_a});
            chk("wdata", {16'd0, o_data}, {16'd0, e_d});
        end

        push   = bus.cpu_wr_en && (sz < DEPTH);
        m_done = 1'b0;
        if (m_clear) begin
            if (!bus.vga_rden) begin
                if (m_idx == WORDS - 1) begin
                    m_clear = 1'b0;
                    m_idx   = 0;
                    m_done  = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (!bus.vga_rden && sz > 0) void'(q.pop_front());
            if (bus.clr_start && sz == 0) begin
                m_clear = 1'b1;
                m_idx   = 0;
                m_fill  = bus.clr_value;
            end
        end
        if (push) q.push_back('{a: bus.cpu_wr_addr, d: bus.cpu_wr_data});
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [15:0] d);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_addr = a;
        bus.cpu_wr_data = d;
        cycle();
        bus.cpu_wr_en   = 1'b0;
    endtask

    task automatic start_clear(input logic [15:0] v);
        bus.clr_start = 1'b1;
        bus.clr_value = v;
        cycle();
        bus.clr_start = 1'b0;
    endtask

    task automatic run_until_done(input int bound, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (o_clr_busy === 1'b1) busy_cycles++;
            if (o_clr_done === 1'b1) break;
        end
        chk("clr_done_seen", {31'd0, o_clr_done}, 32'd1);
    endtask

    initial begin
        int busy_n;
        int once_n;
        checks   = 0;
        failures = 0;
        wr_cnt   = 0;
        bus.cpu_wr_en   = 1'b0;
        bus.cpu_wr_addr = 13'd0;
        bus.cpu_wr_data = 16'd0;
        bus.clr_start   = 1'b0;
        bus.clr_value   = 16'd0;
        bus.vga_rden    = 1'b0;
        model_reset();
        reset = 1'b1;
        #1;
        reset_check();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single write: one-cycle latency, then pending falls.
        cpu_write(13'h0005, 16'hBEEF);
        cycle();
        chk("single_wren",  {31'd0, o_wren}, 32'd1);
        chk("single_addr",  {19'd0, o_addr}, 32'h0005);
        chk("single_data",  {16'd0, o_data}, 32'hBEEF);
        cycle();
        chk("single_pending", {31'd0, o_pending}, 32'd0);

        // Contention: fill the FIFO under scanout, 5th write dropped.
        bus.vga_rden = 1'b1;
        for (int i = 0; i < 4; i++) cpu_write(13'(16 + i), 16'(16'hA000 + i));
        cpu_write(13'h0014, 16'hDEAD);
        chk("cont_busy", {31'd0, o_busy}, 32'd1);
        chk("cont_nowr", {31'd0, o_wren}, 32'd0);
        bus.vga_rden = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("cont_order", {19'd0, o_addr}, 32'(16 + i));
        end
        chk("cont_count", 32'(wr_cnt), 32'd4);
        cycle();
        chk("cont_dropped", {31'd0, o_wren}, 32'd0);

        // Interleave: scanout toggles every cycle, three queued writes.
        bus.vga_rden = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(13'(32 + i), 16'(16'h5000 + i));
        wr_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.vga_rden = (k % 2 == 0);
            cycle();
        end
        chk("ilv_count", 32'(wr_cnt), 32'd3);
        bus.vga_rden = 1'b0;
        cycle();
        chk("ilv_pending", {31'd0, o_pending}, 32'd0);

        // Full clear with 0xFFFF and no contention.
        for (int i = 0; i < WORDS; i++) cov[i] = 0;
        start_clear(16'hFFFF);
        run_until_done(9000, busy_n);
        chk("clr_cycles", 32'(busy_n), 32'd8192);
        once_n = 0;
        for (int i = 0; i < WORDS; i++) if (cov[i] == 1) once_n++;
        chk("clr_cover", 32'(once_n), 32'd8192);
        cycle();
        chk("clr_done_once", {31'd0, o_clr_done}, 32'd0);
        chk("clr_busy_off",  {31'd0, o_clr_busy}, 32'd0);

        // Clear guard: start ignored while pending.
        bus.vga_rden = 1'b1;
        cpu_write(13'h0050, 16'hA5A5);
        start_clear(16'h0000);
        cycle();
        chk("guard_ignored", {31'd0, o_clr_busy}, 32'd0);
        bus.vga_rden = 1'b0;
        cycle();
        cycle();

        // CPU write during a clear lands after the last fill write.
        start_clear(16'h0F0F);
        cpu_write(13'h0100, 16'hC0DE);
        run_until_done(9000, busy_n);
        chk("after_clr_wren", {31'd0, o_wren}, 32'd1);
        chk("after_clr_addr", {19'd0, o_addr}, 32'h0100);
        chk("after_clr_data", {16'd0, o_data}, 32'hC0DE);
        cycle();

        // Reset in the middle of a clear at counter 100.
        start_clear(16'h1234);
        for (int i = 0; i < 100; i++) cycle();
        #2;
        reset = 1'b1;
        #1;
        reset_check();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        start_clear(16'h5555);
        cycle();
        chk("restart_wren", {31'd0, o_wren}, 32'd1);
        chk("restart_addr", {19'd0, o_addr}, 32'h0000);
        chk("restart_data", {16'd0, o_data}, 32'h5555);
        run_until_done(9000, busy_n);

        // Randomized CPU traffic against varying scanout load.
        for (int i = 0; i < 3000; i++) begin
            bus.cpu_wr_en   = 1'($urandom_range(0, 1));
            bus.cpu_wr_addr = 13'($urandom_range(0, WORDS - 1));
            bus.cpu_wr_data = 16'($urandom);
            bus.vga_rden    = ($urandom_range(0, 99) < ((i < 1500) ? 70 : 30));
            cycle();
        end
        bus.cpu_wr_en = 1'b0;
        bus.vga_rden  = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("rand_drained", {31'd0, o_pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
